dense_flatten_buffer: RTL and testbench

- Collects the pooled feature map streamed one pixel (all DEPTH channels) per beat.
- Assembles the H*W*DEPTH flattened vector that the dense stage consumes.
- Sits directly upstream of dense_top; data_o drives its data_i port.
- Ping-pong double buffer: frame N+1 fills while frame N is held stable for the dense stage.

---
 rtl/dense_flatten_buffer.sv | 125 ++++++++++++
 tb/tb_dense_flatten_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_flatten_buffer.sv
// Ping-pong frame buffer. One pixel per beat is collected into raster order and
// presented to the dense stage as one flattened H*W*DEPTH vector.
//
// bank state | meaning
// EMPTY      | no pixels held, free for writing
// FILLING    | part of a frame written, wr_ptr marks the next slot
// FULL       | complete frame held; released by the output handshake
module dense_flatten_buffer #(
  parameter  int H          = 5,
  parameter  int W          = 5,
  parameter  int DEPTH      = 64,
  parameter  int DATA_WIDTH = 32,
  localparam int NUMS       = DEPTH * H * W
) (
  input  logic                         clk,
  input  logic                         rst_i,
  input  logic [DATA_WIDTH*DEPTH-1:0]  pixel_i,
  input  logic                         valid_i,
  input  logic                         sof_i,
  output logic                         ready_o,
  output logic [DATA_WIDTH*NUMS-1:0]   data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         frame_err_o
);

  localparam int PIX   = H * W;
  localparam int PW    = DATA_WIDTH * DEPTH;
  localparam int PTR_W = (PIX > 1) ? $clog2(PIX) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(PIX - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  bank_state_t      bank_q [2];
  bank_state_t      bank_d [2];
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             frame_err_q;

  logic             accept;
  logic             rel;
  logic             sof_restart;
  logic             last_pix;
  logic [PTR_W-1:0] wr_idx;

  logic [PW-1:0]    mem [2][PIX];

  assign ready_o     = (bank_q[wr_bank_q] != FULL);
  assign valid_o     = (bank_q[rd_bank_q] == FULL);
  assign frame_err_o = frame_err_q;

  assign accept      = valid_i && ready_o;
  assign rel         = valid_o && ready_i;
  // A sof in the middle of a frame restarts that frame in the same bank.
  assign sof_restart = accept && sof_i && (wr_ptr_q != '0);
  assign last_pix    = accept && !sof_restart && (wr_ptr_q == LAST_PTR);
  assign wr_idx      = sof_i ? '0 : wr_ptr_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      bank_q[0]   <= EMPTY;
      bank_q[1]   <= EMPTY;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_ptr_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      frame_err_q <= sof_restart;
    end
  end

  // Release always hits the FULL read bank and accept a non-FULL write bank,
  // so both updates below touch different entries when they coincide.
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_ptr_d  = wr_ptr_q;

    if (rel) begin
      bank_d[rd_bank_q] = EMPTY;
      rd_bank_d         = ~rd_bank_q;
    end

    if (accept) begin
      if (sof_restart) begin
        bank_d[wr_bank_q] = FILLING;
        wr_ptr_d          = PTR_W'(1);
      end else if (last_pix) begin
        bank_d[wr_bank_q] = FULL;
        wr_ptr_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        bank_d[wr_bank_q] = FILLING;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
    end
  end

  // Frame storage carries no reset; its contents only matter while valid_o=1.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_bank_q][wr_idx] <= pixel_i;
    end
  end

  always_comb begin
    data_o = '0;
    for (int p = 0; p < PIX; p++) begin
      data_o[p*PW +: PW] = mem[rd_bank_q][p];
    end
  end

endmodule

// File: tb/tb_dense_flatten_buffer.sv
// Bench for dense_flatten_buffer: a small 2x2x2x8 instance for framing corner
// cases and a default-size instance for the two-frame fill and full stall.
module tb_dense_flatten_buffer;

  localparam int SPW   = 16;
  localparam int SBITS = 64;
  localparam int DPW   = 2048;
  localparam int DBITS = 51200;
  localparam int DELEM = 1600;

  logic             clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_s, valid_s, sof_s, rdy_i_s;
  logic [SPW-1:0]   pix_s;
  logic             ready_s, vo_s, err_s;
  logic [SBITS-1:0] data_s;

  logic             rst_d, valid_d, sof_d, rdy_i_d;
  logic [DPW-1:0]   pix_d;
  logic             ready_d, vo_d, err_d;
  logic [DBITS-1:0] data_d;

  dense_flatten_buffer #(.H(2), .W(2), .DEPTH(2), .DATA_WIDTH(8)) dut_s (
    .clk(clk), .rst_i(rst_s), .pixel_i(pix_s), .valid_i(valid_s), .sof_i(sof_s),
    .ready_o(ready_s), .data_o(data_s), .valid_o(vo_s), .ready_i(rdy_i_s),
    .frame_err_o(err_s)
  );

  dense_flatten_buffer dut_d (
    .clk(clk), .rst_i(rst_d), .pixel_i(pix_d), .valid_i(valid_d), .sof_i(sof_d),
    .ready_o(ready_d), .data_o(data_d), .valid_o(vo_d), .ready_i(rdy_i_d),
    .frame_err_o(err_d)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [SBITS-1:0] sq[$];
  logic [DBITS-1:0] dq[$];
  logic [SBITS-1:0] s_exp;
  logic [DBITS-1:0] d_exp;

  // Small config: frame f, pixel p, channel c = f*64 + 16*p + c
  function automatic logic [SPW-1:0] spix(int f, int p);
    return {8'(f*64 + 16*p + 1), 8'(f*64 + 16*p)};
  endfunction

  function automatic logic [SBITS-1:0] sframe(int f);
    logic [SBITS-1:0] r;
    for (int p = 0; p < 4; p++) r[p*SPW +: SPW] = spix(f, p);
    return r;
  endfunction

  // Default config: element = {frame, pixel, channel}
  function automatic logic [DPW-1:0] dpix(int f, int p);
    logic [DPW-1:0] r;
    for (int c = 0; c < 64; c++) r[c*32 +: 32] = {8'(f), 8'(p), 16'(c)};
    return r;
  endfunction

  function automatic logic [DBITS-1:0] dframe(int f);
    logic [DBITS-1:0] r;
    for (int p = 0; p < 25; p++) r[p*DPW +: DPW] = dpix(f, p);
    return r;
  endfunction

  function automatic int first_diff(logic [DBITS-1:0] a, logic [DBITS-1:0] b);
    for (int i = 0; i < DELEM; i++)
      if (a[i*32 +: 32] !== b[i*32 +: 32]) return i;
    return -1;
  endfunction

  task automatic sbeat(input logic [SPW-1:0] px, input logic sof);
    pix_s = px; sof_s = sof; valid_s = 1'b1;
    @(posedge clk); #1;
    valid_s = 1'b0; sof_s = 1'b0;
  endtask

  task automatic dbeat(input logic [DPW-1:0] px, input logic sof);
    pix_d = px; sof_d = sof; valid_d = 1'b1;
    @(posedge clk); #1;
    valid_d = 1'b0; sof_d = 1'b0;
  endtask

  task automatic srelease();
    rdy_i_s = 1'b1;
    @(posedge clk); #1;
    rdy_i_s = 1'b0;
  endtask

  task automatic test_reset();
    rst_s = 1'b1; rst_d = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_s = 1'b0; rst_d = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (vo_s !== 1'b0) begin n_fail++; $display("FAIL reset_valid_s: got %b want 0", vo_s); end
    n_checks++; if (ready_s !== 1'b1) begin n_fail++; $display("FAIL reset_ready_s: got %b want 1", ready_s); end
    n_checks++; if (err_s !== 1'b0) begin n_fail++; $display("FAIL reset_err_s: got %b want 0", err_s); end
    n_checks++; if (vo_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid_d: got %b want 0", vo_d); end
    n_checks++; if (ready_d !== 1'b1) begin n_fail++; $display("FAIL reset_ready_d: got %b want 1", ready_d); end
  endtask

  task automatic test_single_frame();
    rdy_i_s = 1'b0;
    sq.push_back(sframe(0));
    for (int p = 0; p < 4; p++) begin
      n_checks++; if (ready_s !== 1'b1) begin n_fail++; $display("FAIL single_ready p%0d: got %b want 1", p, ready_s); end
      n_checks++; if (vo_s !== 1'b0) begin n_fail++; $display("FAIL single_early_valid p%0d: got %b want 0", p, vo_s); end
      sbeat(spix(0, p), p == 0);
    end
    n_checks++; if (vo_s !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", vo_s); end
    n_checks++; if (ready_s !== 1'b1) begin n_fail++; $display("FAIL single_ready_after: got %b want 1", ready_s); end
    s_exp = sq.pop_front();
    n_checks++; if (data_s !== s_exp) begin n_fail++; $display("FAIL single_data: got %h want %h", data_s, s_exp); end
    n_checks++; if (data_s !== 64'h3130_2120_1110_0100) begin n_fail++; $display("FAIL single_data_const: got %h want 3130212011100100", data_s); end
    repeat (2) @(posedge clk); #1;
    n_checks++; if (vo_s !== 1'b1 || data_s !== s_exp) begin n_fail++; $display("FAIL single_hold: valid %b data %h want 1 %h", vo_s, data_s, s_exp); end
    srelease();
    n_checks++; if (vo_s !== 1'b0) begin n_fail++; $display("FAIL single_release: got %b want 0", vo_s); end
  endtask

  task automatic test_simultaneous();
    sq.push_back(sframe(1));
    for (int p = 0; p < 4; p++) sbeat(spix(1, p), p == 0);
    n_checks++; if (vo_s !== 1'b1) begin n_fail++; $display("FAIL simul_valid1: got %b want 1", vo_s); end
    s_exp = sq.pop_front();
    n_checks++; if (data_s !== s_exp) begin n_fail++; $display("FAIL simul_data1: got %h want %h", data_s, s_exp); end
    sq.push_back(sframe(2));
    for (int p = 0; p < 3; p++) begin
      sbeat(spix(2, p), p == 0);
      n_checks++; if (vo_s !== 1'b1) begin n_fail++; $display("FAIL simul_hold p%0d: got %b want 1", p, vo_s); end
    end
    rdy_i_s = 1'b1;
    sbeat(spix(2, 3), 1'b0);
    rdy_i_s = 1'b0;
    n_checks++; if (vo_s !== 1'b1) begin n_fail++; $display("FAIL simul_valid2: got %b want 1", vo_s); end
    n_checks++; if (ready_s !== 1'b1) begin n_fail++; $display("FAIL simul_ready: got %b want 1", ready_s); end
    s_exp = sq.pop_front();
    n_checks++; if (data_s !== s_exp) begin n_fail++; $display("FAIL simul_data2: got %h want %h", data_s, s_exp); end
    srelease();
    n_checks++; if (vo_s !== 1'b0) begin n_fail++; $display("FAIL simul_release: got %b want 0", vo_s); end
  endtask

  task automatic test_sof_restart();
    sbeat(spix(3, 0), 1'b1);
    n_checks++; if (err_s !== 1'b0) begin n_fail++; $display("FAIL sof_normal_err: got %b want 0", err_s); end
    sbeat(spix(3, 1), 1'b0);
    sq.push_back(sframe(4));
    sbeat(spix(4, 0), 1'b1);
    n_checks++; if (err_s !== 1'b1) begin n_fail++; $display("FAIL sof_err_pulse: got %b want 1", err_s); end
    sbeat(spix(4, 1), 1'b0);
    n_checks++; if (err_s !== 1'b0) begin n_fail++; $display("FAIL sof_err_width: got %b want 0", err_s); end
    sbeat(spix(4, 2), 1'b0);
    n_checks++; if (vo_s !== 1'b0) begin n_fail++; $display("FAIL sof_early_valid: got %b want 0", vo_s); end
    sbeat(spix(4, 3), 1'b0);
    n_checks++; if (vo_s !== 1'b1) begin n_fail++; $display("FAIL sof_valid: got %b want 1", vo_s); end
    s_exp = sq.pop_front();
    n_checks++; if (data_s !== s_exp) begin n_fail++; $display("FAIL sof_data: got %h want %h", data_s, s_exp); end
    srelease();
  endtask

  task automatic test_reset_mid_fill();
    sq.push_back(sframe(5));
    for (int p = 0; p < 4; p++) sbeat(spix(5, p), p == 0);
    s_exp = sq.pop_front();
    n_checks++; if (vo_s !== 1'b1 || data_s !== s_exp) begin n_fail++; $display("FAIL rst_pre: valid %b data %h want 1 %h", vo_s, data_s, s_exp); end
    sbeat(spix(6, 0), 1'b1);
    sbeat(spix(6, 1), 1'b0);
    #2 rst_s = 1'b1;
    #1;
    n_checks++; if (vo_s !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b want 0", vo_s); end
    sq.delete();
    @(negedge clk);
    rst_s = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (vo_s !== 1'b0) begin n_fail++; $display("FAIL rst_after_valid: got %b want 0", vo_s); end
    n_checks++; if (ready_s !== 1'b1) begin n_fail++; $display("FAIL rst_after_ready: got %b want 1", ready_s); end
    sq.push_back(sframe(7));
    for (int p = 0; p < 4; p++) sbeat(spix(7, p), p == 0);
    n_checks++; if (vo_s !== 1'b1) begin n_fail++; $display("FAIL rst_new_valid: got %b want 1", vo_s); end
    s_exp = sq.pop_front();
    n_checks++; if (data_s !== s_exp) begin n_fail++; $display("FAIL rst_new_data: got %h want %h", data_s, s_exp); end
    srelease();
  endtask

  task automatic test_back_to_back();
    int fd;
    rdy_i_d = 1'b0;
    for (int f = 0; f < 3; f++) dq.push_back(dframe(f));
    for (int b = 0; b < 50; b++) begin
      n_checks++; if (ready_d !== 1'b1) begin n_fail++; $display("FAIL b2b_ready beat%0d: got %b want 1", b, ready_d); end
      dbeat(dpix(b / 25, b % 25), (b % 25) == 0);
    end
    n_checks++; if (ready_d !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b want 0", ready_d); end
    n_checks++; if (vo_d !== 1'b1) begin n_fail++; $display("FAIL b2b_valid0: got %b want 1", vo_d); end
    d_exp = dq.pop_front();
    fd = first_diff(data_d, d_exp);
    n_checks++; if (data_d !== d_exp) begin n_fail++; $display("FAIL b2b_frame0: elem %0d got %h want %h", fd, data_d[fd*32 +: 32], d_exp[fd*32 +: 32]); end
    pix_d = dpix(2, 0); sof_d = 1'b1; valid_d = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++; if (ready_d !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_ready: got %b want 0", ready_d); end
    end
    fd = first_diff(data_d, d_exp);
    n_checks++; if (data_d !== d_exp) begin n_fail++; $display("FAIL b2b_frame0_intact: elem %0d got %h want %h", fd, data_d[fd*32 +: 32], d_exp[fd*32 +: 32]); end
    rdy_i_d = 1'b1;
    @(posedge clk); #1;
    rdy_i_d = 1'b0;
    n_checks++; if (vo_d !== 1'b1) begin n_fail++; $display("FAIL b2b_valid1: got %b want 1", vo_d); end
    n_checks++; if (ready_d !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_rel: got %b want 1", ready_d); end
    d_exp = dq.pop_front();
    fd = first_diff(data_d, d_exp);
    n_checks++; if (data_d !== d_exp) begin n_fail++; $display("FAIL b2b_frame1: elem %0d got %h want %h", fd, data_d[fd*32 +: 32], d_exp[fd*32 +: 32]); end
    @(posedge clk); #1;
    valid_d = 1'b0; sof_d = 1'b0;
    for (int p = 1; p < 25; p++) dbeat(dpix(2, p), 1'b0);
    n_checks++; if (ready_d !== 1'b0) begin n_fail++; $display("FAIL b2b_full2_ready: got %b want 0", ready_d); end
    rdy_i_d = 1'b1;
    @(posedge clk); #1;
    rdy_i_d = 1'b0;
    n_checks++; if (vo_d !== 1'b1) begin n_fail++; $display("FAIL b2b_valid2: got %b want 1", vo_d); end
    d_exp = dq.pop_front();
    fd = first_diff(data_d, d_exp);
    n_checks++; if (data_d !== d_exp) begin n_fail++; $display("FAIL b2b_frame2: elem %0d got %h want %h", fd, data_d[fd*32 +: 32], d_exp[fd*32 +: 32]); end
    rdy_i_d = 1'b1;
    @(posedge clk); #1;
    rdy_i_d = 1'b0;
    n_checks++; if (vo_d !== 1'b0 || ready_d !== 1'b1) begin n_fail++; $display("FAIL b2b_drain: valid %b ready %b want 0 1", vo_d, ready_d); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_s = 1'b1; valid_s = 1'b0; sof_s = 1'b0; rdy_i_s = 1'b0; pix_s = '0;
    rst_d = 1'b1; valid_d = 1'b0; sof_d = 1'b0; rdy_i_d = 1'b0; pix_d = '0;
    test_reset();
    test_single_frame();
    test_simultaneous();
    test_sof_restart();
    test_reset_mid_fill();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
